// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-ported memory between
// instruction fetch and data load/store; one access in flight at a time.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LAT        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_stall,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [2:0]            dm_size,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_ack,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [2:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {SRC_IF, SRC_DM} src_t;

    state_t           state, state_nx;
    src_t             owner, last_grant, grant;
    logic             owner_we;
    logic [CNT_W-1:0] cnt;
    logic             issue;

    // On a tie the requester that did not win last time gets the memory.
    always_comb begin
        grant = SRC_IF;
        if (if_req && dm_req) begin
            grant = (last_grant == SRC_IF) ? SRC_DM : SRC_IF;
        end else if (dm_req) begin
            grant = SRC_DM;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= SRC_DM;
            owner      <= SRC_IF;
            owner_we   <= 1'b0;
        end else begin
            state <= state_nx;
            if (issue) begin
                owner      <= grant;
                last_grant <= grant;
                owner_we   <= (grant == SRC_DM) && dm_we;
                cnt        <= CNT_LOAD;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // rst gates the issue strobe so mem_* stay quiet while reset is held.
    always_comb begin
        state_nx  = state;
        issue     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_size  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_ack    = 1'b0;
        if_rdata  = '0;
        dm_ack    = 1'b0;
        dm_rdata  = '0;
        case (state)
            IDLE: begin
                if (rst && (if_req || dm_req)) begin
                    issue    = 1'b1;
                    state_nx = WAIT;
                    mem_req  = 1'b1;
                    if (grant == SRC_DM) begin
                        mem_we    = dm_we;
                        mem_size  = dm_size;
                        mem_addr  = dm_addr;
                        mem_wdata = dm_wdata;
                    end else begin
                        mem_size = 3'b010;
                        mem_addr = if_addr;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                    if (owner == SRC_IF) begin
                        if_ack   = 1'b1;
                        if_rdata = mem_rdata;
                    end else begin
                        dm_ack = 1'b1;
                        if (!owner_we) dm_rdata = mem_rdata;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        if_stall = if_req & ~if_ack;
        dm_stall = dm_req & ~dm_ack;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter at LAT=2 and LAT=1, checked
// every cycle against a timestamp-based model of the arbitration rules.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] init_word(logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    task automatic chk(string name, int lane, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lane%0d %s cyc=%0d actual=%h required=%h", lane, name, cyc, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int L = 2 - g;

        logic        rst, ifq, ifack, ifst, dmq, dmwe, dmack, dmst, mreq, mwe;
        logic [31:0] ifa, ifrd, dma, dmwd, dmrd, maddr, mwd, mrd;
        logic [2:0]  dmsz, msz;
        bit          fin;

        mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LAT(L)) dut (
            .clk(clk), .rst(rst),
            .if_req(ifq), .if_addr(ifa), .if_ack(ifack), .if_rdata(ifrd), .if_stall(ifst),
            .dm_req(dmq), .dm_we(dmwe), .dm_size(dmsz), .dm_addr(dma), .dm_wdata(dmwd),
            .dm_ack(dmack), .dm_rdata(dmrd), .dm_stall(dmst),
            .mem_req(mreq), .mem_we(mwe), .mem_size(msz), .mem_addr(maddr), .mem_wdata(mwd),
            .mem_rdata(mrd)
        );

        // Memory environment: responds to the DUT's strobe, junk on other cycles.
        logic [31:0] tbmem [logic [31:0]];
        int unsigned rd_due[$];
        logic [31:0] rd_dat[$];

        always @(negedge clk) begin
            if (mreq === 1'b1) begin
                if (mwe) tbmem[maddr] = mwd;
                else begin
                    rd_due.push_back(cyc + L);
                    rd_dat.push_back(tbmem.exists(maddr) ? tbmem[maddr] : init_word(maddr));
                end
            end
        end

        always @(posedge clk) begin
            #1;
            while (rd_due.size() > 0 && rd_due[0] < cyc) begin
                void'(rd_due.pop_front());
                void'(rd_dat.pop_front());
            end
            if (rd_due.size() > 0 && rd_due[0] == cyc) begin
                void'(rd_due.pop_front());
                mrd = rd_dat.pop_front();
            end else begin
                mrd = $urandom;
            end
        end

        // Reference model: tracks only who owns the memory and when it frees up.
        bit          busy, own_dm, last_dm, acc_we, if_seen, dm_seen;
        int unsigned ack_at;
        logic [31:0] acc_dat;
        logic [31:0] mmem [logic [31:0]];
        int unsigned iss_cyc[$];
        logic [31:0] iss_addr[$];
        bit          iss_we[$];
        int unsigned ack_cyc[$];
        bit          ack_dm[$];
        logic [31:0] ack_dat[$];

        always @(negedge clk) begin : model
            bit          e_req, e_we, e_ifack, e_dmack, g_dm;
            logic [2:0]  e_sz;
            logic [31:0] e_addr, e_wd, e_ifrd, e_dmrd;
            e_req = 0; e_we = 0; e_ifack = 0; e_dmack = 0; g_dm = 0;
            e_sz = '0; e_addr = '0; e_wd = '0; e_ifrd = '0; e_dmrd = '0;
            if (!rst) begin
                busy    = 0;
                last_dm = 1;
            end else if (busy) begin
                chk("req_held", g, 32'(own_dm ? dmq : ifq), 32'd1);
                if (cyc == ack_at) begin
                    if (own_dm) begin
                        e_dmack = 1;
                        e_dmrd  = acc_we ? '0 : acc_dat;
                    end else begin
                        e_ifack = 1;
                        e_ifrd  = acc_dat;
                    end
                    busy = 0;
                end
            end else if (ifq || dmq) begin
                g_dm   = (ifq && dmq) ? !last_dm : dmq;
                e_req  = 1;
                e_we   = g_dm && dmwe;
                e_sz   = g_dm ? dmsz : 3'b010;
                e_addr = g_dm ? dma : ifa;
                e_wd   = g_dm ? dmwd : '0;
                busy = 1; own_dm = g_dm; last_dm = g_dm; ack_at = cyc + L; acc_we = e_we;
                if (e_we) mmem[e_addr] = e_wd;
                else acc_dat = mmem.exists(e_addr) ? mmem[e_addr] : init_word(e_addr);
            end
            chk("if_ack",    g, 32'(ifack), 32'(e_ifack));
            chk("if_rdata",  g, ifrd, e_ifrd);
            chk("if_stall",  g, 32'(ifst), 32'(ifq & ~e_ifack));
            chk("dm_ack",    g, 32'(dmack), 32'(e_dmack));
            chk("dm_rdata",  g, dmrd, e_dmrd);
            chk("dm_stall",  g, 32'(dmst), 32'(dmq & ~e_dmack));
            chk("mem_req",   g, 32'(mreq), 32'(e_req));
            chk("mem_we",    g, 32'(mwe), 32'(e_we));
            chk("mem_size",  g, 32'(msz), 32'(e_sz));
            chk("mem_addr",  g, maddr, e_addr);
            chk("mem_wdata", g, mwd, e_wd);
            if_seen = (ifack === 1'b1);
            dm_seen = (dmack === 1'b1);
            if (mreq === 1'b1) begin
                iss_cyc.push_back(cyc);
                iss_addr.push_back(maddr);
                iss_we.push_back(mwe);
            end
            if (ifack === 1'b1 || dmack === 1'b1) begin
                ack_cyc.push_back(cyc);
                ack_dm.push_back(dmack === 1'b1);
                ack_dat.push_back((ifack === 1'b1) ? ifrd : dmrd);
            end
        end

        // Requester behaviour: a request is dropped the cycle after its ack.
        task automatic step();
            @(posedge clk);
            #1;
            if (ifq && if_seen) ifq = 1'b0;
            if (dmq && dm_seen) dmq = 1'b0;
        endtask

        task automatic raise_if(logic [31:0] a);
            ifq = 1'b1; ifa = a;
        endtask

        task automatic raise_dm(logic we, logic [2:0] sz, logic [31:0] a, logic [31:0] d);
            dmq = 1'b1; dmwe = we; dmsz = sz; dma = a; dmwd = d;
        endtask

        task automatic clear_logs();
            iss_cyc.delete(); iss_addr.delete(); iss_we.delete();
            ack_cyc.delete(); ack_dm.delete(); ack_dat.delete();
        endtask

        task automatic wait_quiet(int budget);
            for (int i = 0; i < budget; i++) begin
                if (!ifq && !dmq) break;
                step();
            end
            chk("quiet_timeout", g, 32'(ifq | dmq), 32'd0);
        endtask

        task automatic rand_cycles(int n, int pif, int pdm);
            for (int i = 0; i < n; i++) begin
                step();
                if (!ifq && $urandom_range(99) < pif)
                    raise_if(32'h0001_0000 | {26'd0, 4'($urandom), 2'b00});
                if (!dmq && $urandom_range(99) < pdm)
                    raise_dm(1'($urandom), 3'($urandom),
                             32'h0001_0000 | {26'd0, 4'($urandom), 2'b00}, $urandom);
            end
        endtask

        initial begin : stim
            int unsigned t0;
            rst = 1'b0; ifq = 1'b0; ifa = '0; dmq = 1'b0; dmwe = 1'b0;
            dmsz = '0; dma = '0; dmwd = '0; fin = 1'b0;
            repeat (3) step();

            // Both requesters straight out of reset: IF first, DM right after.
            clear_logs();
            raise_if(32'h0000_0100);
            raise_dm(1'b0, 3'b010, 32'h0001_0020, '0);
            rst = 1'b1;
            t0 = cyc;
            wait_quiet(40);
            chk("both_n_acks", g, ack_cyc.size(), 2);
            chk("both_first_if", g, 32'(ack_dm[0]), 0);
            chk("both_if_ack_cyc", g, ack_cyc[0], t0 + L);
            chk("both_dm_issue_cyc", g, iss_cyc[1], t0 + L + 1);
            chk("both_dm_ack_cyc", g, ack_cyc[1], t0 + 2 * L + 1);

            // Continuous contention alternates grants.
            clear_logs();
            rand_cycles(8 * (L + 1), 100, 100);
            wait_quiet(40);
            chk("alt_first_if", g, 32'(ack_dm[0]), 0);
            for (int i = 1; i < 6; i++) begin
                chk("alt_toggle", g, 32'(ack_dm[i] ^ ack_dm[i-1]), 1);
                chk("alt_spacing", g, iss_cyc[i] - iss_cyc[i-1], L + 1);
            end

            // Lone fetch from the boot vector.
            clear_logs();
            raise_if(32'hBFC0_0000);
            t0 = cyc;
            wait_quiet(40);
            chk("if_issue_cyc", g, iss_cyc[0], t0);
            chk("if_issue_addr", g, iss_addr[0], 32'hBFC0_0000);
            chk("if_ack_cyc", g, ack_cyc[0], t0 + L);
            chk("if_rdata_lit", g, ack_dat[0], 32'h43F4_5678);

            // Store then load back the same word.
            clear_logs();
            raise_dm(1'b1, 3'b010, 32'h0001_0000, 32'hDEAD_BEEF);
            t0 = cyc;
            wait_quiet(40);
            chk("st_we", g, 32'(iss_we[0]), 1);
            chk("st_addr", g, iss_addr[0], 32'h0001_0000);
            chk("st_ack_cyc", g, ack_cyc[0], t0 + L);
            chk("st_ack_dm", g, 32'(ack_dm[0]), 1);
            chk("st_rdata_zero", g, ack_dat[0], 32'h0);
            clear_logs();
            raise_dm(1'b0, 3'b010, 32'h0001_0000, '0);
            wait_quiet(40);
            chk("ld_rdata", g, ack_dat[0], 32'hDEAD_BEEF);

            // Back-to-back fetches: one issue every L+1 cycles.
            clear_logs();
            rand_cycles(6 * (L + 1), 100, 0);
            wait_quiet(40);
            for (int i = 1; i < 5; i++) begin
                chk("b2b_spacing", g, iss_cyc[i] - iss_cyc[i-1], L + 1);
                chk("b2b_latency", g, ack_cyc[i] - iss_cyc[i], L);
            end

            // Load arriving while a fetch is outstanding.
            clear_logs();
            raise_if(32'h0001_0004);
            t0 = cyc;
            step();
            raise_dm(1'b0, 3'b010, 32'h0001_0000, '0);
            wait_quiet(40);
            chk("mid_dm_issue_cyc", g, iss_cyc[1], t0 + L + 1);
            chk("mid_dm_ack_cyc", g, ack_cyc[1], t0 + 2 * L + 1);
            chk("mid_dm_rdata", g, ack_dat[1], 32'hDEAD_BEEF);

            // Reset during WAIT: no ack, and the tie-break restarts with IF.
            clear_logs();
            raise_if(32'h0001_0004);
            raise_dm(1'b1, 3'b000, 32'h0001_0008, 32'h0000_00AB);
            step();
            rst = 1'b0;
            step();
            step();
            chk("rst_no_ack", g, ack_cyc.size(), 0);
            chk("rst_one_issue", g, iss_cyc.size(), 1);
            clear_logs();
            rst = 1'b1;
            t0 = cyc;
            wait_quiet(40);
            chk("rst_regrant_cyc", g, iss_cyc[0], t0);
            chk("rst_regrant_if", g, 32'(ack_dm[0]), 0);

            rand_cycles(600, 30, 30);
            rand_cycles(600, 80, 60);
            rand_cycles(400, 10, 90);
            wait_quiet(40);
            fin = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            if (lane[0].fin && lane[1].fin) break;
        end
        checks++;
        if (!(lane[0].fin && lane[1].fin)) begin
            errors++;
            $display("FAIL run_timeout actual=unfinished required=finished");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
